emaxi_rresp_buffer: RTL and testbench
=====================================

# emaxi_rresp_buffer

Read-response stage directly downstream of the eMesh AXI master read bridge. It consumes AXI R-channel beats for the single burst the bridge has committed on AR, counts them against the committed length and checks RLAST/RID/RRESP. Beats are buffered in a small first-word-fall-through FIFO and presented to the eMesh-side response consumer through a valid/ready handshake.

## Interface

Parameters:
- DW, 64, R-channel data width
- IDW, 12, AXI ID width
- DEPTH, 4, FIFO entries, power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- burst_start  in  1  one-cycle pulse on AR commit (arvalid & arready)
- burst_len  in  8  AXI arlen of the committed burst (beats − 1)
- burst_id  in  IDW  arid of the committed burst
- m_axi_rvalid  in  1  R beat valid
- m_axi_rready  out  1  R beat ready
- m_axi_rdata  in  DW  R data
- m_axi_rid  in  IDW  R ID
- m_axi_rlast  in  1  R last
- m_axi_rresp  in  2  R response
- rsp_valid  out  1  head FIFO entry valid
- rsp_ready  in  1  consumer accepts head entry
- rsp_data  out  DW  head entry data
- rsp_last  out  1  head entry is final beat of its burst (by count)
- rsp_err  out  1  head entry had rresp ≠ 2'b00
- busy  out  1  state ≠ IDLE or FIFO not empty
- beat_cnt  out  8  beats accepted in current burst
- err_clear  in  1  clears sticky error flags
- err_rlast  out  1  sticky: RLAST inconsistent with count
- err_id  out  1  sticky: RID ≠ latched burst_id
- err_overlap  out  1  sticky: burst_start while ACTIVE

## Operation

- States: IDLE, ACTIVE.
- IDLE: m_axi_rready = 0. burst_start → latch burst_len into len_q and burst_id into id_q, clear beat_cnt, go ACTIVE. Accepted even if FIFO still holds entries of the previous burst.
- ACTIVE: m_axi_rready = !full. Beat accepted when rvalid & rready.
- On each accepted beat, push {rdata, rresp≠0, final}. final = (beat_cnt == len_q). Then increment beat_cnt.
- Counter is authoritative. On the final beat, go IDLE whether or not rlast is set.
- err_rlast sets on:
  - an accepted beat with rlast=1 and final=0, or
  - an accepted beat with final=1 and rlast=0.
- err_id sets on an accepted beat with rid ≠ id_q. The data is still pushed.
- burst_start in ACTIVE: ignored, sets err_overlap.
- Sticky errors:
  - Clear on err_clear.
  - Set has priority over clear in the same cycle.
- FIFO:
  - First-word fall-through. rsp_valid = !empty; rsp_data/rsp_last/rsp_err come from the head entry.
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
  - When full, rready=0, so there is no push; a pop that cycle frees one slot for the next cycle.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Occupancy: log2(DEPTH)+1 bits, range 0..DEPTH.
- burst_len = 255 gives 256 beats. beat_cnt reaches 255 on the final beat and does not overflow observably, because state returns to IDLE.
- Reset values:
  - State IDLE; FIFO empty.
  - m_axi_rready=0, rsp_valid=0, rsp_data=0, rsp_last=0, rsp_err=0.
  - busy=0, beat_cnt=0, all err_* =0.
- rst mid-burst:
  - Discards FIFO contents and the burst in progress.
  - Beats still owed by the slave are not tracked.
  - Upstream reset of the bridge is coincident.

## Timing

- m_axi_rready is derived only from registered state and occupancy. It has no combinational path from rvalid or rsp_ready.
- burst_start in cycle N → ACTIVE and m_axi_rready=1 in cycle N+1 (FIFO not full).
- Beat accepted in cycle N → rsp_valid=1 in N+1 with that data, if the FIFO was empty.
- Final beat accepted in cycle N → state IDLE and rready=0 in N+1. A burst_start in N+1 is accepted.
- Pop in cycle N while full → rready=1 in N+1 (ACTIVE).
- Sticky flags are visible the cycle after the offending beat.
- Throughput: one beat per cycle sustained while rsp_ready=1.

## Test plan

- burst_len=3, id=5, rvalid every cycle, rlast on 4th beat, rsp_ready=1 → 4 outputs, rsp_last only on 4th, busy falls 1 cycle after last pop, no errors.
- DEPTH=4, burst_len=7, rsp_ready=0 → rready drops after 4 beats. Raising rsp_ready for one cycle → exactly one more beat accepted next cycle. Data order preserved.
- burst_len=1, rlast on beat 1 → err_rlast=1, state stays ACTIVE; beat 2 without rlast accepted as final, state IDLE. err_clear → err_rlast=0.
- rid=6 vs burst_id=5 on beat 0, rresp=2'b10 on beat 1 → err_id=1; head of beat 1 shows rsp_err=1, beat 0 rsp_err=0.
- burst_start pulsed mid-burst → err_overlap=1, len_q/id_q unchanged. burst_len=255 completes with 256 outputs, last flagged.
- rst asserted after 2 of 4 beats → next cycle rready=0, rsp_valid=0, beat_cnt=0, busy=0.

Source files
------------

// File: rtl/emaxi_rresp_buffer.sv
// R-channel response stage for the eMesh AXI read bridge: counts beats of the committed
// burst, flags RLAST/RID/RRESP problems and buffers beats in a small FWFT FIFO.
module emaxi_rresp_buffer #(
  parameter int DW    = 64,
  parameter int IDW   = 12,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           burst_start,
  input  logic [7:0]     burst_len,
  input  logic [IDW-1:0] burst_id,
  input  logic           m_axi_rvalid,
  output logic           m_axi_rready,
  input  logic [DW-1:0]  m_axi_rdata,
  input  logic [IDW-1:0] m_axi_rid,
  input  logic           m_axi_rlast,
  input  logic [1:0]     m_axi_rresp,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_data,
  output logic           rsp_last,
  output logic           rsp_err,
  output logic           busy,
  output logic [7:0]     beat_cnt,
  input  logic           err_clear,
  output logic           err_rlast,
  output logic           err_id,
  output logic           err_overlap
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t         state_q, state_d;
  logic [7:0]     len_q;
  logic [IDW-1:0] id_q;
  logic [7:0]     beat_cnt_q;

  logic [DW+1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;

  logic full, empty, accept, pop, final_beat, start_ok;
  logic set_rlast, set_id, set_overlap;

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign final_beat = (beat_cnt_q == len_q);
  assign start_ok   = burst_start && (state_q == IDLE);

  // rready depends only on registered state and occupancy
  assign m_axi_rready = (state_q == ACTIVE) && !full;
  assign accept       = m_axi_rvalid && m_axi_rready;
  assign pop          = !empty && rsp_ready;

  assign set_rlast   = accept && (m_axi_rlast != final_beat);
  assign set_id      = accept && (m_axi_rid != id_q);
  assign set_overlap = burst_start && (state_q == ACTIVE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (burst_start) state_d = ACTIVE;
      ACTIVE:  if (accept && final_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      id_q       <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        len_q      <= burst_len;
        id_q       <= burst_id;
        beat_cnt_q <= '0;
      end else if (accept && beat_cnt_q != 8'hff) begin
        // saturates so a 256-beat burst leaves 255 rather than wrapping to 0
        beat_cnt_q <= beat_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
      if (accept && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !accept) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= {final_beat, (m_axi_rresp != 2'b00), m_axi_rdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_rlast   <= 1'b0;
      err_id      <= 1'b0;
      err_overlap <= 1'b0;
    end else begin
      err_rlast   <= set_rlast   || (err_rlast   && !err_clear);
      err_id      <= set_id      || (err_id      && !err_clear);
      err_overlap <= set_overlap || (err_overlap && !err_clear);
    end
  end

  // head is masked when empty so stale memory never shows on the outputs
  assign rsp_valid = !empty;
  assign rsp_data  = empty ? '0   : mem[rd_ptr_q][DW-1:0];
  assign rsp_err   = empty ? 1'b0 : mem[rd_ptr_q][DW];
  assign rsp_last  = empty ? 1'b0 : mem[rd_ptr_q][DW+1];
  assign busy      = (state_q != IDLE) || !empty;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_emaxi_rresp_buffer.sv
// Scoreboard bench for emaxi_rresp_buffer: accepted beats queue their expected
// {last, err, data}; a negedge monitor checks each popped head entry in order.
module tb_emaxi_rresp_buffer;

  localparam int DW = 64, IDW = 12, DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           burst_start;
  logic [7:0]     burst_len;
  logic [IDW-1:0] burst_id;
  logic           m_axi_rvalid, m_axi_rready;
  logic [DW-1:0]  m_axi_rdata;
  logic [IDW-1:0] m_axi_rid;
  logic           m_axi_rlast;
  logic [1:0]     m_axi_rresp;
  logic           rsp_valid, rsp_ready;
  logic [DW-1:0]  rsp_data;
  logic           rsp_last, rsp_err, busy;
  logic [7:0]     beat_cnt;
  logic           err_clear, err_rlast, err_id, err_overlap;

  emaxi_rresp_buffer #(.DW(DW), .IDW(IDW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .burst_start(burst_start), .burst_len(burst_len),
    .burst_id(burst_id), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rid(m_axi_rid), .m_axi_rlast(m_axi_rlast),
    .m_axi_rresp(m_axi_rresp), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy),
    .beat_cnt(beat_cnt), .err_clear(err_clear), .err_rlast(err_rlast),
    .err_id(err_id), .err_overlap(err_overlap)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  logic [DW+1:0] sb [$];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("spurious_rsp", 72'd1, 72'd0);
      else chk("rsp_head", {6'd0, rsp_last, rsp_err, rsp_data}, {6'd0, sb.pop_front()});
      n_out++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start(input logic [7:0] len, input logic [IDW-1:0] id);
    burst_start = 1'b1; burst_len = len; burst_id = id;
    step();
    burst_start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [IDW-1:0] id,
                           input logic last, input logic [1:0] resp, input logic exp_final);
    int w = 0;
    bit done = 0;
    m_axi_rvalid = 1'b1; m_axi_rdata = d; m_axi_rid = id;
    m_axi_rlast = last; m_axi_rresp = resp;
    while (!done) begin
      @(negedge clk);
      if (m_axi_rready) begin
        sb.push_back({exp_final, (resp != 2'b00), d});
        done = 1;
      end else if (++w > 200) begin
        chk("beat_timeout", 72'd0, 72'd1);
        done = 1;
      end
      @(posedge clk); #1;
    end
    m_axi_rvalid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    rsp_ready = 1'b1;
    while (sb.size() != 0 && w < 400) begin step(); w++; end
    chk("drain_left", 72'(sb.size()), 72'd0);
  endtask

  task automatic clear_errs();
    err_clear = 1'b1; step(); err_clear = 1'b0;
  endtask

  initial begin
    int base, t0;
    rst = 1'b1; burst_start = 0; burst_len = 0; burst_id = 0;
    m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
    rsp_ready = 0; err_clear = 0;
    step(); step();
    rst = 1'b0;
    chk("rst_rready", 72'(m_axi_rready), 72'd0);
    chk("rst_rsp_valid", 72'(rsp_valid), 72'd0);
    chk("rst_rsp_data", 72'(rsp_data), 72'd0);
    chk("rst_rsp_last_err", 72'({rsp_last, rsp_err}), 72'd0);
    chk("rst_busy", 72'(busy), 72'd0);
    chk("rst_beat_cnt", 72'(beat_cnt), 72'd0);
    chk("rst_errs", 72'({err_rlast, err_id, err_overlap}), 72'd0);

    // basic 4-beat burst, full throughput
    start(8'd3, 12'd5);
    chk("start_rready", 72'(m_axi_rready), 72'd1);
    rsp_ready = 1'b1;
    base = n_out; t0 = $time;
    for (int i = 0; i < 4; i++) send_beat(64'($urandom) << 8 | 64'(i), 12'd5, i == 3, 2'b00, i == 3);
    chk("throughput_cycles", 72'(($time - t0) / 10), 72'd4);
    chk("final_rready", 72'(m_axi_rready), 72'd0);
    chk("busy_before_pop", 72'(busy), 72'd1);
    step();
    chk("busy_after_pop", 72'(busy), 72'd0);
    chk("basic_outputs", 72'(n_out - base), 72'd4);
    chk("basic_errs", 72'({err_rlast, err_id, err_overlap}), 72'd0);

    // backpressure: FIFO fills after DEPTH beats
    rsp_ready = 1'b0;
    start(8'd7, 12'd5);
    for (int i = 0; i < 4; i++) send_beat(64'h100 + 64'(i), 12'd5, 1'b0, 2'b00, 1'b0);
    chk("full_rready", 72'(m_axi_rready), 72'd0);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    chk("pop_frees_rready", 72'(m_axi_rready), 72'd1);
    send_beat(64'h104, 12'd5, 1'b0, 2'b00, 1'b0);
    chk("refull_rready", 72'(m_axi_rready), 72'd0);
    rsp_ready = 1'b1;
    for (int i = 5; i < 8; i++) send_beat(64'h100 + 64'(i), 12'd5, i == 7, 2'b00, i == 7);
    drain();

    // early rlast; counter stays authoritative
    start(8'd1, 12'd5);
    send_beat(64'h200, 12'd5, 1'b1, 2'b00, 1'b0);
    chk("early_rlast_err", 72'(err_rlast), 72'd1);
    chk("early_rlast_active", 72'(m_axi_rready), 72'd1);
    send_beat(64'h201, 12'd5, 1'b0, 2'b00, 1'b1);
    chk("missing_rlast_idle", 72'(m_axi_rready), 72'd0);
    clear_errs();
    chk("rlast_cleared", 72'(err_rlast), 72'd0);
    drain();

    // bad RID on beat 0, SLVERR on beat 1
    start(8'd1, 12'd5);
    send_beat(64'h300, 12'd6, 1'b0, 2'b00, 1'b0);
    chk("rid_err", 72'(err_id), 72'd1);
    send_beat(64'h301, 12'd5, 1'b1, 2'b10, 1'b1);
    chk("rid_no_rlast_err", 72'(err_rlast), 72'd0);
    drain();
    clear_errs();
    chk("rid_cleared", 72'(err_id), 72'd0);

    // 256-beat burst with an overlapping burst_start in the middle
    start(8'd255, 12'd3);
    base = n_out;
    for (int i = 0; i < 256; i++) begin
      if (i == 10) begin
        start(8'd2, 12'd9);
        chk("overlap_err", 72'(err_overlap), 72'd1);
      end
      send_beat(64'h4000 + 64'(i), 12'd3, i == 255, 2'b00, i == 255);
    end
    chk("long_idle", 72'(m_axi_rready), 72'd0);
    chk("long_no_id_err", 72'({err_rlast, err_id}), 72'd0);
    drain();
    chk("long_outputs", 72'(n_out - base), 72'd256);
    clear_errs();
    chk("overlap_cleared", 72'(err_overlap), 72'd0);

    // reset in the middle of a burst
    rsp_ready = 1'b0;
    start(8'd3, 12'd7);
    send_beat(64'h500, 12'd7, 1'b0, 2'b00, 1'b0);
    send_beat(64'h501, 12'd7, 1'b0, 2'b00, 1'b0);
    chk("pre_rst_cnt", 72'(beat_cnt), 72'd2);
    rst = 1'b1; step(); rst = 1'b0;
    sb.delete();
    chk("midrst_rready", 72'(m_axi_rready), 72'd0);
    chk("midrst_rsp_valid", 72'(rsp_valid), 72'd0);
    chk("midrst_beat_cnt", 72'(beat_cnt), 72'd0);
    chk("midrst_busy", 72'(busy), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
